// File: rtl/dz_matrix_scan.sv
// Row-multiplexed 8x8 red/green dot-matrix driver for the countdown digit.
// The digit is latched only at frame start, so a frame never shows two different digits.
module dz_matrix_scan #(
    parameter int SCAN_DIV     = 125,
    parameter int BLANK        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] dz_cnt,
    output logic [7:0] row,
    output logic [7:0] colr,
    output logic [7:0] colg
);

    localparam int PW = 10;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_row_idx;
    logic [2:0]    r_dig;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_ph;
    logic          r_active;
    logic [7:0]    r_row;
    logic [7:0]    r_colr;
    logic [7:0]    r_colg;

    logic          w_tc;
    logic          w_frame;
    logic [PW-1:0] w_presc_nxt;
    logic [2:0]    w_idx_nxt;
    logic [2:0]    w_dig_nxt;
    logic [BW-1:0] w_blink_cnt_nxt;
    logic          w_blink_ph_nxt;
    logic          w_active_nxt;
    logic          w_blank;
    logic [7:0]    w_pat;
    logic [7:0]    w_row_nxt;
    logic [7:0]    w_colr_nxt;
    logic [7:0]    w_colg_nxt;

    // Glyph rows packed top row in the MSB byte
    function automatic logic [7:0] f_glyph(input logic [2:0] d, input logic [2:0] r);
        logic [63:0] g;
        case (d)
            3'd0:    g = 64'h3C666E7666663C00;
            3'd1:    g = 64'h183818181818_7E00;
            3'd2:    g = 64'h3C66060C30607E00;
            3'd3:    g = 64'h3C66061C06663C00;
            3'd4:    g = 64'h0C1C3C6C7E0C0C00;
            3'd5:    g = 64'h7E607C0606663C00;
            3'd6:    g = 64'h3C607C6666663C00;
            default: g = 64'h7E060C1830303000;
        endcase
        g = g << {r, 3'b000};
        return g[63:56];
    endfunction

    assign w_tc         = (r_presc == PW'(SCAN_DIV - 1));
    assign w_frame      = w_tc && (r_row_idx == 3'd7);
    assign w_presc_nxt  = w_tc ? '0 : r_presc + 1'b1;
    assign w_idx_nxt    = w_tc ? r_row_idx + 3'd1 : r_row_idx;
    assign w_dig_nxt    = w_frame ? dz_cnt : r_dig;
    assign w_active_nxt = r_active | w_tc;
    assign w_blank      = !w_active_nxt || (int'({22'd0, w_presc_nxt}) < BLANK);
    assign w_pat        = f_glyph(w_dig_nxt, w_idx_nxt);
    assign w_row_nxt    = w_active_nxt ? ~(8'b1 << w_idx_nxt) : 8'hFF;

    // Blink advances only on frame starts that follow a frame already showing 0
    always_comb begin
        w_blink_cnt_nxt = r_blink_cnt;
        w_blink_ph_nxt  = r_blink_ph;
        if (w_frame) begin
            if (dz_cnt != 3'd0) begin
                w_blink_cnt_nxt = '0;
                w_blink_ph_nxt  = 1'b1;
            end else if (r_dig == 3'd0) begin
                if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    w_blink_cnt_nxt = '0;
                    w_blink_ph_nxt  = ~r_blink_ph;
                end else begin
                    w_blink_cnt_nxt = r_blink_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_colr_nxt = 8'h00;
        w_colg_nxt = 8'h00;
        if (!w_blank) begin
            case (w_dig_nxt)
                3'd0: w_colr_nxt = w_blink_ph_nxt ? w_pat : 8'h00;
                3'd1, 3'd2: begin
                    w_colr_nxt = w_pat;
                    w_colg_nxt = w_pat;
                end
                default: w_colg_nxt = w_pat;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc     <= '0;
            r_row_idx   <= 3'd7;
            r_dig       <= 3'd0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b1;
            r_active    <= 1'b0;
            r_row       <= 8'hFF;
            r_colr      <= 8'h00;
            r_colg      <= 8'h00;
        end else begin
            r_presc     <= w_presc_nxt;
            r_row_idx   <= w_idx_nxt;
            r_dig       <= w_dig_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_ph  <= w_blink_ph_nxt;
            r_active    <= w_active_nxt;
            r_row       <= w_row_nxt;
            r_colr      <= w_colr_nxt;
            r_colg      <= w_colg_nxt;
        end
    end

    assign row  = r_row;
    assign colr = r_colr;
    assign colg = r_colg;

endmodule

// File: tb/tb_dz_matrix_scan.sv
// Directed bench for dz_matrix_scan: scan timing, glyphs, colours, blink, frame latching, reset.
// Instance a uses SCAN_DIV=4/BLANK=1/BLINK_FRAMES=2, instance b uses SCAN_DIV=2/BLANK=0.
module tb_dz_matrix_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst2;
    logic [2:0] dz;
    logic [2:0] dz2;
    logic [7:0] a_row, a_r, a_g;
    logic [7:0] b_row, b_r, b_g;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    dz_matrix_scan #(.SCAN_DIV(4), .BLANK(1), .BLINK_FRAMES(2)) u_a (
        .clk(clk), .rst(rst), .dz_cnt(dz), .row(a_row), .colr(a_r), .colg(a_g)
    );

    dz_matrix_scan #(.SCAN_DIV(2), .BLANK(0), .BLINK_FRAMES(1)) u_b (
        .clk(clk), .rst(rst2), .dz_cnt(dz2), .row(b_row), .colr(b_r), .colg(b_g)
    );

    localparam logic [63:0] GL [8] = '{
        64'h3C666E7666663C00, 64'h1838181818187E00,
        64'h3C66060C30607E00, 64'h3C66061C06663C00,
        64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00,
        64'h3C607C6666663C00, 64'h7E060C1830303000
    };

    function automatic logic [7:0] gb(input int d, input int r);
        logic [63:0] g;
        g = GL[d];
        return g[63 - 8*r -: 8];
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One row period of instance a: blank cycle then three lit cycles
    task automatic period_a(input int r, input logic [7:0] red, input logic [7:0] grn);
        logic [7:0] rexp;
        rexp = ~(8'h01 << r);
        chk("a_row_blank", a_row, rexp);
        chk("a_colr_blank", a_r, 8'h00);
        chk("a_colg_blank", a_g, 8'h00);
        step();
        repeat (3) begin
            chk("a_row", a_row, rexp);
            chk("a_colr", a_r, red);
            chk("a_colg", a_g, grn);
            step();
        end
    endtask

    task automatic frame_a(input int d, input bit red_on, input bit grn_on, input int lo, input int hi);
        for (int r = lo; r <= hi; r++)
            period_a(r, red_on ? gb(d, r) : 8'h00, grn_on ? gb(d, r) : 8'h00);
    endtask

    task automatic idle_a();
        for (int i = 0; i < 4; i++) begin
            chk("a_row_idle", a_row, 8'hFF);
            chk("a_colr_idle", a_r, 8'h00);
            chk("a_colg_idle", a_g, 8'h00);
            step();
        end
    endtask

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        dz   = 3'd5;
        dz2  = 3'd1;
        step();
        step();
        chk("a_row_reset", a_row, 8'hFF);
        chk("a_colr_reset", a_r, 8'h00);
        chk("a_colg_reset", a_g, 8'h00);
        rst = 1'b0;
        idle_a();

        // digit 5 frame; the change to 2 must wait for the next frame start
        frame_a(5, 0, 1, 0, 0);
        dz = 3'd2;
        frame_a(5, 0, 1, 1, 7);

        frame_a(2, 1, 1, 0, 0);
        dz = 3'd7;
        frame_a(2, 1, 1, 1, 7);

        frame_a(7, 0, 1, 0, 1);
        dz = 3'd4;
        frame_a(7, 0, 1, 2, 7);

        frame_a(4, 0, 1, 0, 0);
        dz = 3'd0;
        frame_a(4, 0, 1, 1, 7);

        // zero blinks red with two-frame half-periods
        frame_a(0, 1, 0, 0, 7);
        frame_a(0, 1, 0, 0, 7);
        frame_a(0, 0, 0, 0, 7);
        frame_a(0, 0, 0, 0, 7);
        frame_a(0, 1, 0, 0, 7);
        frame_a(0, 1, 0, 0, 0);
        dz = 3'd3;
        frame_a(0, 1, 0, 1, 7);

        // non-zero digit clears blink state: next zero frame starts lit
        frame_a(3, 0, 1, 0, 0);
        dz = 3'd0;
        frame_a(3, 0, 1, 1, 7);

        frame_a(0, 1, 0, 0, 3);
        chk("a_row_mid", a_row, 8'hEF);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_a();
        frame_a(0, 1, 0, 0, 0);

        // instance b: no blanking, two-cycle rows
        rst2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("b_row_idle", b_row, 8'hFF);
            chk("b_colr_idle", b_r, 8'h00);
            step();
        end
        for (int r = 0; r < 7; r++) begin
            repeat (2) begin
                chk("b_row", b_row, ~(8'h01 << r));
                chk("b_colr", b_r, gb(1, r));
                chk("b_colg", b_g, gb(1, r));
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
